// File: rtl/conv_bram_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_bram_host_pkg
//  Purpose  : Shared state encodings and default widths for conv_bram_host.
//  Contents : state_t, ST_HOST/ST_KICK/ST_BUSY/ST_DONE,
//             DEF_ADDR_BW / DEF_DATA_BW / DEF_CYC_BW
//  Revision : 1.0 - initial release
// ============================================================================
package conv_bram_host_pkg;

   typedef logic [1:0] state_t;

   // Ownership state machine encodings; these values are visible on o_state.
   localparam state_t ST_HOST = 2'd0;  // host owns the buffer
   localparam state_t ST_KICK = 2'd1;  // one-cycle start pulse to the engine
   localparam state_t ST_BUSY = 2'd2;  // engine owns the buffer
   localparam state_t ST_DONE = 2'd3;  // engine finished, host may read back

   localparam int DEF_ADDR_BW = 8;
   localparam int DEF_DATA_BW = 32;
   localparam int DEF_CYC_BW  = 32;

endpackage : conv_bram_host_pkg
`default_nettype wire

// File: rtl/conv_bram_host_mem.sv
`default_nettype none
// ============================================================================
//  Module   : conv_bram_host_mem
//  Purpose  : Single-clock word buffer, one registered read-first read port
//             and one write port. Contents are not reset.
//  Ports    : clk                         - clock, rising edge
//             i_rd_en / i_rd_addr         - read request
//             o_rd_data                   - read data, one cycle after i_rd_en
//             i_wr_en / i_wr_addr / i_wr_data - write port
//  Revision : 1.0 - initial release
// ============================================================================
module conv_bram_host_mem #(
   parameter int ADDR_BW = 8,
   parameter int DATA_BW = 32
) (
   input  logic               clk,
   input  logic               i_rd_en,
   input  logic [ADDR_BW-1:0] i_rd_addr,
   output logic [DATA_BW-1:0] o_rd_data,
   input  logic               i_wr_en,
   input  logic [ADDR_BW-1:0] i_wr_addr,
   input  logic [DATA_BW-1:0] i_wr_data
);

   localparam int DEPTH = 2 ** ADDR_BW;

   logic [DATA_BW-1:0] mem_q [0:DEPTH-1];
   logic [DATA_BW-1:0] rd_data_q;

   // Both updates are non-blocking, so a same-address read in the write
   // cycle samples the old word (read-first).
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         rd_data_q <= mem_q[i_rd_addr];
      end
   end

   assign o_rd_data = rd_data_q;

endmodule : conv_bram_host_mem
`default_nettype wire

// File: rtl/conv_bram_host.sv
`default_nettype none
// ============================================================================
//  Module   : conv_bram_host
//  Purpose  : Responder side of the convolution engine buffer interface.
//             Owns the word buffer, serves the engine read/write ports while
//             the engine owns it, gives the host load/readback access
//             otherwise, and sequences HOST -> KICK -> BUSY -> DONE.
//  Ports    : ACLK, ARESET (sync, active-high)
//             engine : i_r_en/i_r_addr/o_r_data, i_w_en/i_w_addr/i_w_data,
//                      o_w_done (start pulse), i_done (completion)
//             host   : i_h_req/i_h_we/i_h_addr/i_h_wdata, o_h_ready,
//                      o_h_rvalid/o_h_rdata, i_start, i_clear
//             status : o_state, o_err (sticky), o_cycles (run length)
//  Revision : 1.0 - initial release
// ============================================================================
module conv_bram_host
   import conv_bram_host_pkg::*;
#(
   parameter int AXI_ADDR_BW = DEF_ADDR_BW,
   parameter int AXI_DATA_BW = DEF_DATA_BW,
   parameter int CYC_BW      = DEF_CYC_BW
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   i_r_en,
   input  logic [AXI_ADDR_BW-1:0] i_r_addr,
   output logic [AXI_DATA_BW-1:0] o_r_data,
   input  logic                   i_w_en,
   input  logic [AXI_ADDR_BW-1:0] i_w_addr,
   input  logic [AXI_DATA_BW-1:0] i_w_data,
   output logic                   o_w_done,
   input  logic                   i_done,
   input  logic                   i_h_req,
   input  logic                   i_h_we,
   input  logic [AXI_ADDR_BW-1:0] i_h_addr,
   input  logic [AXI_DATA_BW-1:0] i_h_wdata,
   output logic                   o_h_ready,
   output logic                   o_h_rvalid,
   output logic [AXI_DATA_BW-1:0] o_h_rdata,
   input  logic                   i_start,
   input  logic                   i_clear,
   output logic [1:0]             o_state,
   output logic                   o_err,
   output logic [CYC_BW-1:0]      o_cycles
);

   localparam logic [CYC_BW-1:0] C_CYC_ONE = {{(CYC_BW-1){1'b0}}, 1'b1};
   localparam logic [CYC_BW-1:0] C_CYC_MAX = {CYC_BW{1'b1}};

   state_t                 state_q,   state_d;
   logic                   wdone_q,   wdone_d;
   logic                   err_q,     err_d;
   logic [CYC_BW-1:0]      cycles_q,  cycles_d;
   logic                   eng_rd_q,  eng_rd_d;   // engine read issued last cycle
   logic                   h_rd_q,    h_rd_d;     // host read issued last cycle
   logic [AXI_DATA_BW-1:0] rdata_q,   rdata_d;
   logic [AXI_DATA_BW-1:0] hrdata_q,  hrdata_d;

   logic                   w_busy;
   logic                   w_h_acc;
   logic                   w_mem_rd_en;
   logic [AXI_ADDR_BW-1:0] w_mem_rd_addr;
   logic                   w_mem_wr_en;
   logic [AXI_ADDR_BW-1:0] w_mem_wr_addr;
   logic [AXI_DATA_BW-1:0] w_mem_wr_data;
   logic [AXI_DATA_BW-1:0] w_mem_rdata;

   assign w_busy    = (state_q == ST_BUSY);
   assign o_h_ready = (state_q == ST_HOST) || (state_q == ST_DONE);
   assign w_h_acc   = i_h_req && o_h_ready;

   // Host and engine own the buffer in disjoint states, so the state alone
   // selects which side drives the memory ports. Writes are suppressed while
   // reset is asserted so a reset cycle leaves the buffer untouched.
   always_comb begin
      w_mem_rd_en   = 1'b0;
      w_mem_rd_addr = i_h_addr;
      w_mem_wr_en   = 1'b0;
      w_mem_wr_addr = i_h_addr;
      w_mem_wr_data = i_h_wdata;
      if (w_busy) begin
         w_mem_rd_en   = i_r_en;
         w_mem_rd_addr = i_r_addr;
         w_mem_wr_en   = i_w_en && !ARESET;
         w_mem_wr_addr = i_w_addr;
         w_mem_wr_data = i_w_data;
      end else begin
         w_mem_rd_en   = w_h_acc && !i_h_we;
         w_mem_wr_en   = w_h_acc && i_h_we && !ARESET;
      end
   end

   conv_bram_host_mem #(
      .ADDR_BW (AXI_ADDR_BW),
      .DATA_BW (AXI_DATA_BW)
   ) u_mem (
      .clk       (ACLK),
      .i_rd_en   (w_mem_rd_en),
      .i_rd_addr (w_mem_rd_addr),
      .o_rd_data (w_mem_rdata),
      .i_wr_en   (w_mem_wr_en),
      .i_wr_addr (w_mem_wr_addr),
      .i_wr_data (w_mem_wr_data)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOST: if (i_start) state_d = ST_KICK;
         ST_KICK: state_d = ST_BUSY;
         ST_BUSY: if (i_done)  state_d = ST_DONE;
         ST_DONE: if (i_clear) state_d = ST_HOST;
         default: state_d = ST_HOST;
      endcase
   end

   always_comb begin
      // Start pulse is registered on the HOST->KICK transition so it is high
      // for exactly the single KICK cycle.
      wdone_d = (state_q == ST_HOST) && i_start;

      // Engine activity outside BUSY is a protocol violation; sticky.
      err_d = err_q
            | (i_done && !w_busy)
            | ((i_r_en || i_w_en) && !w_busy);

      cycles_d = cycles_q;
      if ((state_q == ST_HOST) && i_start) begin
         cycles_d = '0;
      end else if ((state_q == ST_KICK) || w_busy) begin
         if (cycles_q != C_CYC_MAX) begin
            cycles_d = cycles_q + C_CYC_ONE;
         end
      end

      eng_rd_d = w_busy && i_r_en;
      h_rd_d   = w_h_acc && !i_h_we;

      // The memory read register is shared by both sides; each output keeps
      // its own holding copy so one side's reads never disturb the other.
      rdata_d  = eng_rd_q ? w_mem_rdata : rdata_q;
      hrdata_d = h_rd_q   ? w_mem_rdata : hrdata_q;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= ST_HOST;
         wdone_q  <= 1'b0;
         err_q    <= 1'b0;
         cycles_q <= '0;
         eng_rd_q <= 1'b0;
         h_rd_q   <= 1'b0;
         rdata_q  <= '0;
         hrdata_q <= '0;
      end else begin
         state_q  <= state_d;
         wdone_q  <= wdone_d;
         err_q    <= err_d;
         cycles_q <= cycles_d;
         eng_rd_q <= eng_rd_d;
         h_rd_q   <= h_rd_d;
         rdata_q  <= rdata_d;
         hrdata_q <= hrdata_d;
      end
   end

   assign o_r_data   = rdata_d;
   assign o_h_rdata  = hrdata_d;
   assign o_h_rvalid = h_rd_q;
   assign o_w_done   = wdone_q;
   assign o_state    = state_q;
   assign o_err      = err_q;
   assign o_cycles   = cycles_q;

endmodule : conv_bram_host
`default_nettype wire

// File: doc/conv_bram_host.md
Name: conv_bram_host

Overview:
- Responder side of the convolution engine's buffer interface.
- Owns the shared word buffer and serves the engine's read port (r_en/r_addr/r_data) and write port (w_en/w_addr/w_data).
- Generates the engine's start pulse and consumes its completion flag.
- Gives a simple host (register/DMA side) load and readback access, and arbitrates ownership with a small state machine.

Parameters:
- AXI_ADDR_BW, 8, word-address width; buffer depth = 2**AXI_ADDR_BW words.
- AXI_DATA_BW, 32, word width.
- CYC_BW, 32, width of the busy-cycle counter.

Ports:
- ACLK  in  1  sole clock, rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- i_r_en  in  1  engine read request.
- i_r_addr  in  AXI_ADDR_BW  engine read address.
- o_r_data  out  AXI_DATA_BW  engine read data, valid 1 cycle after accepted i_r_en.
- i_w_en  in  1  engine write strobe.
- i_w_addr  in  AXI_ADDR_BW  engine write address.
- i_w_data  in  AXI_DATA_BW  engine write data.
- o_w_done  out  1  one-cycle start pulse to the engine ("input loaded").
- i_done  in  1  engine completion level/pulse.
- i_h_req  in  1  host access request.
- i_h_we  in  1  host write (1) / read (0).
- i_h_addr  in  AXI_ADDR_BW  host address.
- i_h_wdata  in  AXI_DATA_BW  host write data.
- o_h_ready  out  1  host access accepted this cycle when i_h_req=1.
- o_h_rvalid  out  1  host read data valid (1-cycle pulse).
- o_h_rdata  out  AXI_DATA_BW  host read data.
- i_start  in  1  host command: hand buffer to engine.
- i_clear  in  1  host command: acknowledge completion.
- o_state  out  2  current FSM state encoding.
- o_err  out  1  sticky protocol-error flag.
- o_cycles  out  CYC_BW  engine run length in cycles.

Behaviour:
- Clock and reset: one clock (ACLK). Reset is synchronous and active-high (ARESET).
- Reset values: state=HOST, o_w_done=0, o_r_data=0, o_h_rvalid=0, o_h_rdata=0, o_err=0, o_cycles=0. Buffer contents are not reset.
- States:
  - HOST=0, KICK=1, BUSY=2, DONE=3.
  - HOST: i_start -> KICK.
  - KICK: unconditionally -> BUSY. o_w_done=1 only in KICK, registered so it is high exactly one cycle.
  - BUSY: i_done -> DONE.
  - DONE: i_clear -> HOST.
  - i_start outside HOST and i_clear outside DONE are ignored.
  - i_done outside BUSY is ignored and sets o_err.
- Ownership:
  - Engine ports are honoured only in BUSY.
  - i_r_en or i_w_en asserted in any other state is dropped (no memory change, o_r_data holds) and sets o_err.
  - o_h_ready = (state==HOST || state==DONE), combinational from state. Host access happens only when i_h_req && o_h_ready.
  - A host request in KICK/BUSY stalls: o_h_ready=0, nothing is lost, and it is not an error.
- Latency:
  - Engine read: 1 cycle, o_r_data registered.
  - Host read: 1 cycle, o_h_rvalid pulses the cycle after acceptance; o_h_rdata holds until the next host read.
  - Writes land at the clock edge; a read of that address in the next cycle returns the new value.
- Same-cycle same-address engine read and write: read-first, so o_r_data returns the old word.
- Host and engine never access in the same cycle (exclusive states), so there is no arbitration tie.
- i_start and i_h_req in the same HOST cycle: the host access completes and the state still moves to KICK.
- i_done in the same cycle as a BUSY engine write: the write commits and the state moves to DONE.
- Address wrap: addresses are exactly AXI_ADDR_BW wide with no out-of-range case. The top address 2**AXI_ADDR_BW-1 is valid.
- o_cycles:
  - Cleared to 0 on entering KICK, then increments each cycle in KICK and BUSY.
  - Saturates at all-ones.
  - Frozen in DONE and HOST until the next KICK.
- o_err is cleared only by ARESET.
- ARESET mid-BUSY returns to HOST next edge, clears all outputs, and emits no o_w_done. The engine is reset by the same reset.

Decomposition:
- Package conv_bram_host_pkg: state encodings (HOST/KICK/BUSY/DONE) and default widths (ADDR 8, DATA 32, CYC 32).
- One sub-module: conv_bram_host_mem, a single-clock memory with one read-first registered read port and one write port. The top muxes host/engine address and enables into it by state.

Test Plan:
- Reset, then host writes 0xA5A5_0001..0xA5A5_0004 to addr 0..3, then reads them back -> o_h_rvalid 1 cycle after each read, with matching data; o_state=0, o_err=0.
- i_start in HOST -> o_w_done high exactly one cycle (state 1), then state 2. Engine reads addr 2 -> o_r_data=0xA5A5_0003 next cycle. i_done after 10 BUSY cycles -> state 3, o_cycles=11.
- In BUSY, engine writes 0x1234 to addr 255 while reading addr 255 in the same cycle -> read returns old value. A host request held during BUSY gets o_h_ready=0 until DONE. The host read of 255 in DONE returns 0x1234.
- Engine i_w_en while in HOST, and i_done while in HOST -> memory unchanged, o_err=1 and stays 1. i_clear in HOST is ignored.
- ARESET asserted mid-BUSY -> next cycle state=0, o_w_done=0, o_cycles=0, o_err=0, and previously written buffer data is still readable.
- Force o_cycles near saturation with CYC_BW=4 and hold BUSY for 20 cycles -> o_cycles stays at 15.
